ap_err_monitor: RTL and testbench
=================================

// Module: ap_err_monitor
// PURPOSE
//  Receive-side error evaluator for the approximate unsigned Wallace multipliers.
//  - Consumes a stream of (exact, approximate) product pairs.
//  - Accumulates error statistics over a run of N_SAMPLES pairs: error count, sum of
//    error distance (ED) and maximum ED.
//  - Results are read out for ER/MED reporting of each evolved compressor set.
//  - Sits after the DUT multiplier and a reference exact multiplier in the eval harness.
// PARAMETERS
//  PW         16     product width (2x operand width)
//  N_SAMPLES  65536  pairs per run (exhaustive 8x8 sweep); range 1..2**20
//  ACC_W      32     width of the sum_ed accumulator
//  CW         $clog2(N_SAMPLES+1)  derived localparam; width of the counters
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin a run; sampled in IDLE only
//  s_valid    in   1      input pair valid
//  s_ready    out  1      block accepts a pair
//  s_exact    in   PW     exact product
//  s_approx   in   PW     approximate product
//  busy       out  1      run in progress (RUN or DRAIN)
//  done       out  1      one-cycle pulse; results are final
//  sample_cnt out  CW     pairs accepted in the current/last run
//  err_cnt    out  CW     pairs with exact != approx
//  sum_ed     out  ACC_W  sum of |exact - approx|; saturating
//  sum_sat    out  1      sum_ed has saturated in this run
//  max_ed     out  PW     largest ED in the run
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (s_ready, busy, done, counters, sum_ed,
//    sum_sat, max_ed).
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    - IDLE->RUN on start. Entering RUN clears sample_cnt, err_cnt, sum_ed, sum_sat,
//      max_ed and the pipeline valids.
//    - RUN: s_ready=1. A pair is accepted when s_valid & s_ready. sample_cnt
//      increments on each accept.
//    - The accept that makes sample_cnt == N_SAMPLES moves RUN->DRAIN; s_ready=0 from
//      the next cycle.
//    - DRAIN lasts 2 cycles (pipeline flush), then DONE.
//    - DONE: done=1 for exactly one cycle, then IDLE.
//  - s_valid gaps: no accept, no state change; counters hold.
//  - Pipeline:
//    - stage1 registers ed = |exact-approx| (PW bits, unsigned) and neq = (exact!=approx).
//    - stage2 updates err_cnt += neq, sum_ed += ed, max_ed = max(max_ed, ed).
//  - Latency: last accept in cycle T -> stage1 at T+1 -> accumulators final at T+2
//    -> done high in cycle T+3.
//  - Saturation: if sum_ed + ed exceeds 2**ACC_W-1, sum_ed = all-ones and sum_sat=1.
//    sum_sat stays set until the next start.
//  - start outside IDLE is ignored; a start in the DONE cycle is also ignored.
//  - Results hold their values in IDLE until the next start.
//  - s_ready is 0 in IDLE, DRAIN and DONE; s_exact and s_approx are don't-care when
//    not accepted.
//  - busy = (state==RUN) | (state==DRAIN).
//  - rst_n low mid-run: immediate return to the reset values. No done pulse and no
//    partial results are retained.
// STRUCTURE
//  - ap_eval_pkg: FSM state enum (IDLE/RUN/DRAIN/DONE), DRAIN_CYC=2, and the shared
//    ED/counter width functions for the other evaluation blocks.
//  - One sub-module, ap_abs_diff: combinational |a-b| and a!=b, PW-parameterised.
//  - Everything else (FSM, pipeline, accumulators) stays in ap_err_monitor.
// TESTING
//  1. N_SAMPLES=256, approx==exact for all pairs, s_valid held high -> err_cnt=0,
//     sum_ed=0, max_ed=0, sample_cnt=256; done 3 cycles after the last accept.
//  2. N_SAMPLES=4, pairs (100,96),(7,7),(5,9),(0,65535) -> err_cnt=3,
//     sum_ed=4+4+65535=65543, max_ed=65535.
//  3. Random s_valid gaps (50% duty) over a 1000-pair run -> results identical to a
//     gap-free run; s_ready drops the cycle after the 1000th accept.
//  4. ACC_W=17, 4 pairs each with ED=65535 -> sum_ed=131071, sum_sat=1. The next
//     start clears both to 0.
//  5. start pulsed in RUN, DRAIN and DONE -> ignored, no counter clear; start in IDLE
//     after done -> all results cleared in the next cycle.
//  6. rst_n low for 1 cycle after 10 accepts -> all outputs 0, state IDLE, no done
//     pulse; a fresh run afterwards yields correct results.

Source files
------------

// File: rtl/ap_eval_pkg.sv
// Shared definitions for the approximate-multiplier evaluation blocks:
// run-control FSM states, drain length and width helpers.
package ap_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ap_state_e;

  // Cycles spent flushing the two-stage datapath after the last accept.
  localparam int DRAIN_CYC = 2;

  // Width of an error distance between two PW-bit products.
  function automatic int ed_width(input int pw);
    return pw;
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ap_err_monitor_if.sv
// Product-pair stream: a source presents (exact, approx) with valid,
// the monitor accepts with ready.
interface ap_err_monitor_if #(
  parameter int PW = 16
);
  logic          valid;
  logic          ready;
  logic [PW-1:0] exact;
  logic [PW-1:0] approx;

  modport master (output valid, output exact, output approx, input ready);
  modport slave  (input valid, input exact, input approx, output ready);
endinterface

// File: rtl/ap_abs_diff.sv
// Combinational error distance |a-b| and inequality flag for one pair.
module ap_abs_diff #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         neq_o
);

  // Subtract the smaller from the larger so the result never wraps.
  always_comb begin
    diff_o = '0;
    if (a_i > b_i) begin
      diff_o = a_i - b_i;
    end else begin
      diff_o = b_i - a_i;
    end
    neq_o = (a_i != b_i);
  end

endmodule

// File: rtl/ap_err_monitor.sv
// Error statistics over a run of N_SAMPLES (exact, approx) pairs:
// error count, saturating ED sum and maximum ED, behind a 2-stage pipeline.
module ap_err_monitor
  import ap_eval_pkg::*;
#(
  parameter  int PW        = 16,
  parameter  int N_SAMPLES = 65536,
  parameter  int ACC_W     = 32,
  localparam int CW        = cnt_width(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  ap_err_monitor_if.slave  s_if,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    sample_cnt_o,
  output logic [CW-1:0]    err_cnt_o,
  output logic [ACC_W-1:0] sum_ed_o,
  output logic             sum_sat_o,
  output logic [PW-1:0]    max_ed_o
);

  localparam int                EW         = ed_width(PW);
  localparam int                DW         = cnt_width(DRAIN_CYC);
  localparam logic [CW-1:0]     LAST_CNT   = CW'(N_SAMPLES - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX    = {ACC_W{1'b1}};

  ap_state_e        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             accept_s, clear_s;
  logic [EW-1:0]    ed_s;
  logic             neq_s;
  logic             s1_vld_q, s1_neq_q;
  logic [EW-1:0]    s1_ed_q;
  logic [CW-1:0]    cnt_q, err_q;
  logic [ACC_W-1:0] sum_q;
  logic             sat_q;
  logic [EW-1:0]    max_q;
  logic [ACC_W:0]   sum_ext_s;

  ap_abs_diff #(.W(PW)) u_abs_diff (
    .a_i    (s_if.exact),
    .b_i    (s_if.approx),
    .diff_o (ed_s),
    .neq_o  (neq_s)
  );

  // Run-control next state: start in IDLE, count accepts, fixed drain, one-cycle DONE.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    accept_s = 1'b0;
    clear_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        accept_s = s_if.valid;
        if (accept_s && (cnt_q == LAST_CNT)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and drain-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Stage 1: capture ED and inequality of each accepted pair; count accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_neq_q <= 1'b0;
      s1_ed_q  <= '0;
      cnt_q    <= '0;
    end else if (clear_s) begin
      s1_vld_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= accept_s;
      if (accept_s) begin
        s1_ed_q  <= ed_s;
        s1_neq_q <= neq_s;
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

  assign sum_ext_s = {1'b0, sum_q} + (ACC_W + 1)'(s1_ed_q);

  // Stage 2: fold the registered pair into the run accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      sum_q <= '0;
      sat_q <= 1'b0;
      max_q <= '0;
    end else if (clear_s) begin
      err_q <= '0;
      sum_q <= '0;
      sat_q <= 1'b0;
      max_q <= '0;
    end else if (s1_vld_q) begin
      err_q <= err_q + CW'(s1_neq_q);
      if (sum_ext_s[ACC_W]) begin
        sum_q <= ACC_MAX;
        sat_q <= 1'b1;
      end else begin
        sum_q <= sum_ext_s[ACC_W-1:0];
      end
      if (s1_ed_q > max_q) begin
        max_q <= s1_ed_q;
      end
    end
  end

  assign s_if.ready   = (state_q == RUN);
  assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
  assign done_o       = (state_q == DONE);
  assign sample_cnt_o = cnt_q;
  assign err_cnt_o    = err_q;
  assign sum_ed_o     = sum_q;
  assign sum_sat_o    = sat_q;
  assign max_ed_o     = max_q;

endmodule

// File: tb/tb_ap_err_monitor.sv
// Bench for ap_err_monitor: four instances with different N_SAMPLES/ACC_W,
// random and directed pair streams checked against a plain-arithmetic model.
module tb_ap_err_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_r [4];
  logic        valid_r [4];
  logic [15:0] exact_r [4];
  logic [15:0] approx_r[4];
  logic [3:0]  ready_w, busy_w, done_w, sat_w;
  logic [31:0] cnt_w[4], err_w[4], sum_w[4];
  logic [15:0] max_w[4];

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int N = (g == 0) ? 256 : (g == 2) ? 1000 : 4;
    localparam int A = (g == 3) ? 17 : 32;
    localparam int C = $clog2(N + 1);
    ap_err_monitor_if #(.PW(16)) bus ();
    logic [C-1:0] cnt_s, err_s;
    logic [A-1:0] sum_s;
    logic [15:0]  max_s;
    assign bus.valid   = valid_r[g];
    assign bus.exact   = exact_r[g];
    assign bus.approx  = approx_r[g];
    assign ready_w[g]  = bus.ready;
    ap_err_monitor #(.PW(16), .N_SAMPLES(N), .ACC_W(A)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_r[g]), .s_if(bus.slave),
      .busy_o(busy_w[g]), .done_o(done_w[g]), .sample_cnt_o(cnt_s),
      .err_cnt_o(err_s), .sum_ed_o(sum_s), .sum_sat_o(sat_w[g]), .max_ed_o(max_s));
    assign cnt_w[g] = 32'(cnt_s);
    assign err_w[g] = 32'(err_s);
    assign sum_w[g] = 32'(sum_s);
    assign max_w[g] = max_s;
  end

  int vec = 0;
  int errs = 0;

  logic [15:0] pe_q[$];
  logic [15:0] pa_q[$];
  int     exp_cnt, exp_err;
  longint exp_sum, exp_max;
  bit     exp_sat;

  int last_cyc, done_cyc, done_hits, timed_out;
  logic ready_after;
  logic [31:0] ps_cnt, ps_err, ps_sum;
  logic [15:0] ps_max;
  logic ps_sat, ps_busy;

  // Reference: statistics of the queued pairs, sum clipped to 2**aw-1.
  task automatic model(input int aw);
    longint lim, e;
    lim = (longint'(1) << aw) - 1;
    exp_cnt = pe_q.size(); exp_err = 0; exp_sum = 0; exp_max = 0;
    foreach (pe_q[i]) begin
      e = longint'(pe_q[i]) - longint'(pa_q[i]);
      if (e < 0) e = -e;
      if (e != 0) exp_err++;
      exp_sum += e;
      if (e > exp_max) exp_max = e;
    end
    exp_sat = (exp_sum > lim);
    if (exp_sat) exp_sum = lim;
  endtask

  // Fill the pair queues: mode 0 approx==exact, mode 1 assorted errors.
  task automatic gen(input int n, input int mode);
    logic [15:0] p;
    pe_q.delete(); pa_q.delete();
    for (int i = 0; i < n; i++) begin
      p = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      pe_q.push_back(p);
      if (mode == 0) pa_q.push_back(p);
      else case ($urandom_range(0, 3))
        0:       pa_q.push_back(p);
        1:       pa_q.push_back(p ^ 16'($urandom_range(0, 255)));
        2:       pa_q.push_back(16'($urandom));
        default: pa_q.push_back(p & 16'hFF00);
      endcase
    end
  endtask

  // Start a run on lane ln and stream the queue; records timing observations.
  task automatic feed(input int ln, input bit gaps, input bit poke, input int abort_at);
    int idx, guard, stop_n;
    bit acc;
    idx = 0; guard = 0; timed_out = 0; done_cyc = -1; done_hits = 0; last_cyc = -1;
    stop_n = (abort_at > 0) ? abort_at : pe_q.size();
    @(posedge clk); #1; start_r[ln] = 1'b1;
    @(posedge clk); #1; start_r[ln] = 1'b0;
    ps_cnt = cnt_w[ln]; ps_err = err_w[ln]; ps_sum = sum_w[ln];
    ps_max = max_w[ln]; ps_sat = sat_w[ln]; ps_busy = busy_w[ln];
    while (idx < stop_n && guard < 5000) begin
      valid_r[ln] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_r[ln]) begin
        exact_r[ln] = pe_q[idx]; approx_r[ln] = pa_q[idx];
      end else begin
        exact_r[ln] = 16'($urandom); approx_r[ln] = 16'($urandom);
      end
      start_r[ln] = poke && (idx == stop_n / 2);
      acc = valid_r[ln] && ready_w[ln];
      if (acc && idx == stop_n - 1) last_cyc = cyc;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    valid_r[ln] = 1'b0; start_r[ln] = 1'b0;
    if (idx < stop_n) timed_out = 1;
    ready_after = ready_w[ln];
    if (abort_at == 0) begin
      for (int k = 0; k < 8; k++) begin
        start_r[ln] = poke && (k < 3);
        if (done_w[ln]) begin done_hits++; done_cyc = cyc; end
        @(posedge clk); #1;
      end
      start_r[ln] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int ln = 0; ln < 4; ln++) begin
      vec++;
      if ({ready_w[ln], busy_w[ln], done_w[ln], sat_w[ln]} !== 4'b0 ||
          cnt_w[ln] !== 32'd0 || err_w[ln] !== 32'd0 || sum_w[ln] !== 32'd0 || max_w[ln] !== 16'd0) begin
        errs++;
        $display("FAIL reset lane%0d got rdy=%b busy=%b done=%b sat=%b cnt=%0d err=%0d sum=%0d max=%0d want all 0",
                 ln, ready_w[ln], busy_w[ln], done_w[ln], sat_w[ln], cnt_w[ln], err_w[ln], sum_w[ln], max_w[ln]);
      end
    end
  endtask

  task automatic test_exact_match();
    gen(256, 0);
    feed(0, 1'b0, 1'b0, 0);
    vec++;
    if (cnt_w[0] !== 32'd256 || err_w[0] !== 32'd0 || sum_w[0] !== 32'd0 || max_w[0] !== 16'd0 || sat_w[0] !== 1'b0) begin
      errs++;
      $display("FAIL exact_results got cnt=%0d err=%0d sum=%0d max=%0d sat=%b want 256/0/0/0/0",
               cnt_w[0], err_w[0], sum_w[0], max_w[0], sat_w[0]);
    end
    vec++;
    if (timed_out != 0 || done_cyc != last_cyc + 3 || done_hits != 1) begin
      errs++;
      $display("FAIL exact_done_timing got done_cyc=%0d hits=%0d timeout=%0d want %0d/1/0",
               done_cyc, done_hits, timed_out, last_cyc + 3);
    end
    vec++;
    if (ps_busy !== 1'b1 || ready_after !== 1'b0) begin
      errs++;
      $display("FAIL exact_busy_ready got busy=%b ready_after=%b want 1/0", ps_busy, ready_after);
    end
  endtask

  task automatic test_directed();
    pe_q = '{16'd100, 16'd7, 16'd5, 16'd0};
    pa_q = '{16'd96,  16'd7, 16'd9, 16'd65535};
    feed(1, 1'b0, 1'b0, 0);
    vec++;
    if (cnt_w[1] !== 32'd4 || err_w[1] !== 32'd3 || sum_w[1] !== 32'd65543 || max_w[1] !== 16'd65535 || sat_w[1] !== 1'b0) begin
      errs++;
      $display("FAIL directed_results got cnt=%0d err=%0d sum=%0d max=%0d sat=%b want 4/3/65543/65535/0",
               cnt_w[1], err_w[1], sum_w[1], max_w[1], sat_w[1]);
    end
    vec++;
    if (done_cyc != last_cyc + 3 || done_hits != 1) begin
      errs++;
      $display("FAIL directed_done got cyc=%0d hits=%0d want %0d/1", done_cyc, done_hits, last_cyc + 3);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] g_cnt, g_err, g_sum;
    logic [15:0] g_max;
    gen(1000, 1);
    model(32);
    feed(2, 1'b1, 1'b0, 0);
    g_cnt = cnt_w[2]; g_err = err_w[2]; g_sum = sum_w[2]; g_max = max_w[2];
    vec++;
    if (g_cnt !== 32'(exp_cnt) || g_err !== 32'(exp_err) || g_sum !== 32'(exp_sum) ||
        g_max !== 16'(exp_max) || sat_w[2] !== exp_sat) begin
      errs++;
      $display("FAIL gaps_results got cnt=%0d err=%0d sum=%0d max=%0d sat=%b want %0d/%0d/%0d/%0d/%b",
               g_cnt, g_err, g_sum, g_max, sat_w[2], exp_cnt, exp_err, exp_sum, exp_max, exp_sat);
    end
    vec++;
    if (timed_out != 0 || ready_after !== 1'b0 || done_cyc != last_cyc + 3 || done_hits != 1) begin
      errs++;
      $display("FAIL gaps_timing got timeout=%0d ready_after=%b done_cyc=%0d hits=%0d want 0/0/%0d/1",
               timed_out, ready_after, done_cyc, done_hits, last_cyc + 3);
    end
    feed(2, 1'b0, 1'b0, 0);
    vec++;
    if (ps_cnt !== 32'd0 || ps_err !== 32'd0 || ps_sum !== 32'd0 || ps_max !== 16'd0) begin
      errs++;
      $display("FAIL gaps_restart_clear got cnt=%0d err=%0d sum=%0d max=%0d want 0", ps_cnt, ps_err, ps_sum, ps_max);
    end
    vec++;
    if (cnt_w[2] !== g_cnt || err_w[2] !== g_err || sum_w[2] !== g_sum || max_w[2] !== g_max) begin
      errs++;
      $display("FAIL gapfree_vs_gaps got cnt=%0d err=%0d sum=%0d max=%0d want %0d/%0d/%0d/%0d",
               cnt_w[2], err_w[2], sum_w[2], max_w[2], g_cnt, g_err, g_sum, g_max);
    end
  endtask

  task automatic test_saturation();
    pe_q = '{16'd65535, 16'd0, 16'd65535, 16'd0};
    pa_q = '{16'd0, 16'd65535, 16'd0, 16'd65535};
    feed(3, 1'b0, 1'b0, 0);
    vec++;
    if (sum_w[3] !== 32'd131071 || sat_w[3] !== 1'b1 || err_w[3] !== 32'd4 || max_w[3] !== 16'd65535) begin
      errs++;
      $display("FAIL sat_results got sum=%0d sat=%b err=%0d max=%0d want 131071/1/4/65535",
               sum_w[3], sat_w[3], err_w[3], max_w[3]);
    end
    pe_q = '{16'd10, 16'd10, 16'd10, 16'd10};
    pa_q = '{16'd7, 16'd7, 16'd7, 16'd7};
    feed(3, 1'b0, 1'b0, 0);
    vec++;
    if (ps_sum !== 32'd0 || ps_sat !== 1'b0) begin
      errs++;
      $display("FAIL sat_clear_on_start got sum=%0d sat=%b want 0/0", ps_sum, ps_sat);
    end
    vec++;
    if (sum_w[3] !== 32'd12 || sat_w[3] !== 1'b0) begin
      errs++;
      $display("FAIL sat_next_run got sum=%0d sat=%b want 12/0", sum_w[3], sat_w[3]);
    end
  endtask

  task automatic test_start_ignored();
    gen(256, 1);
    model(32);
    feed(0, 1'b0, 1'b1, 0);
    vec++;
    if (cnt_w[0] !== 32'(exp_cnt) || err_w[0] !== 32'(exp_err) || sum_w[0] !== 32'(exp_sum) ||
        max_w[0] !== 16'(exp_max) || done_hits != 1) begin
      errs++;
      $display("FAIL start_ignored_results got cnt=%0d err=%0d sum=%0d max=%0d hits=%0d want %0d/%0d/%0d/%0d/1",
               cnt_w[0], err_w[0], sum_w[0], max_w[0], done_hits, exp_cnt, exp_err, exp_sum, exp_max);
    end
    vec++;
    if (busy_w[0] !== 1'b0 || ready_w[0] !== 1'b0) begin
      errs++;
      $display("FAIL start_in_done_idle got busy=%b ready=%b want 0/0", busy_w[0], ready_w[0]);
    end
    gen(256, 0);
    feed(0, 1'b0, 1'b0, 0);
    vec++;
    if (ps_cnt !== 32'd0 || ps_err !== 32'd0 || ps_sum !== 32'd0 || ps_max !== 16'd0 || ps_sat !== 1'b0) begin
      errs++;
      $display("FAIL idle_start_clear got cnt=%0d err=%0d sum=%0d max=%0d sat=%b want 0",
               ps_cnt, ps_err, ps_sum, ps_max, ps_sat);
    end
  endtask

  task automatic test_reset_midrun();
    int hits;
    gen(256, 1);
    feed(0, 1'b0, 1'b0, 10);
    vec++;
    if (cnt_w[0] !== 32'd10 || busy_w[0] !== 1'b1) begin
      errs++;
      $display("FAIL midrun_pre got cnt=%0d busy=%b want 10/1", cnt_w[0], busy_w[0]);
    end
    rst_n = 1'b0;
    #2;
    vec++;
    if ({ready_w[0], busy_w[0], done_w[0], sat_w[0]} !== 4'b0 || cnt_w[0] !== 32'd0 ||
        err_w[0] !== 32'd0 || sum_w[0] !== 32'd0 || max_w[0] !== 16'd0) begin
      errs++;
      $display("FAIL midrun_reset got rdy=%b busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d want 0",
               ready_w[0], busy_w[0], done_w[0], cnt_w[0], err_w[0], sum_w[0], max_w[0]);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_w[0] || busy_w[0]) hits++;
      @(posedge clk); #1;
    end
    vec++;
    if (hits != 0) begin
      errs++;
      $display("FAIL midrun_no_done got %0d active cycles want 0", hits);
    end
    model(32);
    feed(0, 1'b0, 1'b0, 0);
    vec++;
    if (cnt_w[0] !== 32'(exp_cnt) || err_w[0] !== 32'(exp_err) || sum_w[0] !== 32'(exp_sum) ||
        max_w[0] !== 16'(exp_max) || done_cyc != last_cyc + 3) begin
      errs++;
      $display("FAIL midrun_fresh_run got cnt=%0d err=%0d sum=%0d max=%0d done_cyc=%0d want %0d/%0d/%0d/%0d/%0d",
               cnt_w[0], err_w[0], sum_w[0], max_w[0], done_cyc, exp_cnt, exp_err, exp_sum, exp_max, last_cyc + 3);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_r[i] = 1'b0; valid_r[i] = 1'b0; exact_r[i] = 16'd0; approx_r[i] = 16'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_exact_match();
    test_directed();
    test_gaps();
    test_saturation();
    test_start_ignored();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
